// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing the narrow port of the IOPMP BRAM width converter
// between NUM_REQ requesters, with a read-data watchdog.
module bram_port_arbiter #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned OUT_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned TIMEOUT    = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NUM_REQ-1:0]                   req_i,
   input  logic [NUM_REQ-1:0]                   we_i,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_i,
   input  logic [NUM_REQ-1:0][OUT_WIDTH-1:0]    wdata_i,
   output logic [NUM_REQ-1:0]                   gnt_o,
   output logic [NUM_REQ-1:0]                   rsp_valid_o,
   output logic                                 rsp_err_o,
   output logic [OUT_WIDTH-1:0]                 rdata_o,
   output logic                                 busy_o,
   output logic                                 err_o,
   output logic                                 conv_en_o,
   output logic                                 conv_we_o,
   output logic [ADDR_WIDTH-1:0]                conv_addr_o,
   output logic [OUT_WIDTH-1:0]                 conv_din_o,
   input  logic [OUT_WIDTH-1:0]                 conv_dout_i,
   input  logic                                 conv_valid_i,
   input  logic                                 conv_ready_i
);

   localparam int unsigned IDX_W   = $clog2(NUM_REQ);
   localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               err_q, err_d;

   logic               found;
   logic [IDX_W-1:0]   winner;
   logic [IDX_W-1:0]   cand;

   // Round-robin search: first active request after the last winner, wrapping.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         cand = IDX_W'((int'(last_q) + k) % int'(NUM_REQ));
         if (!found && req_i[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // NOTE: every output and next-state signal gets a default first so no path
   // through the case statement leaves one unassigned and infers a latch.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      timer_d     = timer_q;
      err_d       = err_q;
      gnt_o       = '0;
      rsp_valid_o = '0;
      rsp_err_o   = 1'b0;
      rdata_o     = '0;
      conv_en_o   = 1'b0;
      conv_we_o   = 1'b0;
      conv_addr_o = '0;
      conv_din_o  = '0;

      unique case (state_q)
         IDLE: begin
            if (found && conv_ready_i) begin
               gnt_o[winner] = 1'b1;
               conv_en_o     = 1'b1;
               conv_we_o     = we_i[winner];
               conv_addr_o   = addr_i[winner];
               conv_din_o    = wdata_i[winner];
               owner_d       = winner;
               last_d        = winner;
               timer_d       = '0;
               state_d       = we_i[winner] ? WR_WAIT : RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (conv_valid_i) begin
               rsp_valid_o[owner_q] = 1'b1;
               rdata_o              = conv_dout_i;
               timer_d              = '0;
               state_d              = IDLE;
            end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
               // Watchdog expiry: complete with an error so the owner is not stuck.
               rsp_valid_o[owner_q] = 1'b1;
               rsp_err_o            = 1'b1;
               err_d                = 1'b1;
               timer_d              = '0;
               state_d              = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         WR_WAIT: begin
            rsp_valid_o[owner_q] = 1'b1;
            state_d              = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         last_q  <= IDX_W'(NUM_REQ - 1);
         owner_q <= '0;
         timer_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         timer_q <= timer_d;
         err_q   <= err_d;
      end
   end

   assign busy_o = (state_q != IDLE);
   assign err_o  = err_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios plus randomized
// traffic checked every cycle against a transaction-level reference model.
module tb_bram_port_arbiter;

   localparam int NUM_REQ = 2;
   localparam int OUT_W   = 32;
   localparam int ADDR_W  = 7;
   localparam int TMO     = 4;

   logic                          clk_i = 1'b0;
   logic                          rst_ni;
   logic [NUM_REQ-1:0]            req_i, we_i;
   logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i;
   logic [NUM_REQ-1:0][OUT_W-1:0]  wdata_i;
   logic [NUM_REQ-1:0]            gnt_o, rsp_valid_o;
   logic                          rsp_err_o, busy_o, err_o;
   logic [OUT_W-1:0]              rdata_o;
   logic                          conv_en_o, conv_we_o;
   logic [ADDR_W-1:0]             conv_addr_o;
   logic [OUT_W-1:0]              conv_din_o, conv_dout_i;
   logic                          conv_valid_i, conv_ready_i;

   int n_checks = 0;
   int n_pass   = 0;

   bram_port_arbiter #(
      .NUM_REQ(NUM_REQ), .OUT_WIDTH(OUT_W), .ADDR_WIDTH(ADDR_W), .TIMEOUT(TMO)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
      .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rdata_o(rdata_o),
      .busy_o(busy_o), .err_o(err_o), .conv_en_o(conv_en_o),
      .conv_we_o(conv_we_o), .conv_addr_o(conv_addr_o),
      .conv_din_o(conv_din_o), .conv_dout_i(conv_dout_i),
      .conv_valid_i(conv_valid_i), .conv_ready_i(conv_ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] mem_init(input int a);
      return 32'hA5A4_FFFC + 32'(a);
   endfunction

   // Converter model: busy for the cycle after an issue, read data one cycle later.
   logic              stall, no_valid;
   logic              conv_busy, rd_pend;
   logic [OUT_W-1:0]  conv_mem [128];

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         conv_busy   <= 1'b0;
         rd_pend     <= 1'b0;
         conv_dout_i <= '0;
         for (int i = 0; i < 128; i++) conv_mem[i] <= mem_init(i);
      end else begin
         conv_busy <= conv_en_o;
         rd_pend   <= conv_en_o && !conv_we_o;
         if (conv_en_o && conv_we_o) conv_mem[conv_addr_o] <= conv_din_o;
         conv_dout_i <= (conv_en_o && !conv_we_o) ? conv_mem[conv_addr_o] : $urandom;
      end
   end

   assign conv_ready_i = !conv_busy && !stall;
   assign conv_valid_i = rd_pend && !no_valid;

   // Reference model: one outstanding transaction, round-robin pick by arithmetic.
   logic [OUT_W-1:0]  ref_mem [128];
   bit                m_busy, m_we, m_err;
   int                m_owner, m_last, m_issue, cyc;
   logic [ADDR_W-1:0] m_addr;

   function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
      for (int k = 1; k <= NUM_REQ; k++)
         if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      return -1;
   endfunction

   always @(negedge clk_i) begin
      logic [NUM_REQ-1:0] e_gnt, e_rsp;
      logic               e_err, e_en, e_we;
      logic [OUT_W-1:0]   e_rdata, e_din;
      logic [ADDR_W-1:0]  e_addr;
      int                 w;
      if (!rst_ni) begin
         m_busy = 0; m_err = 0; m_last = NUM_REQ - 1; m_owner = 0;
         for (int i = 0; i < 128; i++) ref_mem[i] = mem_init(i);
         check("rst_gnt", 32'(gnt_o), 0);
         check("rst_rsp", 32'(rsp_valid_o), 0);
         check("rst_busy", 32'(busy_o), 0);
         check("rst_err", 32'(err_o), 0);
         check("rst_conv_en", 32'(conv_en_o), 0);
      end else begin
         e_gnt = '0; e_rsp = '0; e_err = 0; e_rdata = '0;
         e_en = 0; e_we = 0; e_addr = '0; e_din = '0;
         w = -1;
         if (m_busy) begin
            if (m_we) e_rsp[m_owner] = 1'b1;
            else if (conv_valid_i) begin
               e_rsp[m_owner] = 1'b1;
               e_rdata = ref_mem[m_addr];
            end else if (cyc - m_issue == TMO) begin
               e_rsp[m_owner] = 1'b1;
               e_err = 1'b1;
            end
         end else if (conv_ready_i) begin
            w = rr_pick(req_i, m_last);
            if (w >= 0) begin
               e_gnt[w] = 1'b1;
               e_en = 1; e_we = we_i[w]; e_addr = addr_i[w]; e_din = wdata_i[w];
            end
         end
         check("gnt", 32'(gnt_o), 32'(e_gnt));
         check("rsp_valid", 32'(rsp_valid_o), 32'(e_rsp));
         check("rsp_err", 32'(rsp_err_o), 32'(e_err));
         check("rdata", rdata_o, e_rdata);
         check("busy", 32'(busy_o), 32'(m_busy));
         check("err", 32'(err_o), 32'(m_err));
         check("conv_en", 32'(conv_en_o), 32'(e_en));
         check("conv_we", 32'(conv_we_o), 32'(e_we));
         check("conv_addr", 32'(conv_addr_o), 32'(e_addr));
         check("conv_din", conv_din_o, e_din);
         if (e_rsp != 0) begin
            m_busy = 0;
            if (e_err) m_err = 1;
         end else if (w >= 0) begin
            m_busy = 1; m_owner = w; m_last = w; m_we = e_we;
            m_addr = e_addr; m_issue = cyc;
            if (e_we) ref_mem[e_addr] = e_din;
         end
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   logic [NUM_REQ-1:0] g;

   initial begin
      cyc = 0;
      rst_ni = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
      stall = 1'b0; no_valid = 1'b0;
      repeat (2) @(negedge clk_i);
      step(); rst_ni = 1'b1;

      // Single read from requester 0.
      step(); req_i = 2'b01; we_i = 2'b00; addr_i[0] = 7'h05;
      @(negedge clk_i); check("rd_gnt", 32'(gnt_o), 32'h1);
      step(); req_i = '0;
      @(negedge clk_i); check("rd_rsp", 32'(rsp_valid_o), 32'h1);
      check("rd_data", rdata_o, 32'hA5A5_0001);
      step();
      @(negedge clk_i); check("rd_busy_after", 32'(busy_o), 0);

      // Single write from requester 1.
      step(); req_i = 2'b10; we_i = 2'b10; addr_i[1] = 7'h12; wdata_i[1] = 32'hCAFE_F00D;
      @(negedge clk_i);
      check("wr_en", 32'(conv_en_o), 1);
      check("wr_we", 32'(conv_we_o), 1);
      check("wr_addr", 32'(conv_addr_o), 32'h12);
      check("wr_din", conv_din_o, 32'hCAFE_F00D);
      step(); req_i = '0; we_i = '0;
      @(negedge clk_i); check("wr_rsp", 32'(rsp_valid_o), 32'h2);

      // Fairness: both requesting continuously.
      for (int c = 0; c < 12; c++) begin
         step(); req_i = 2'b11; addr_i[0] = 7'(c); addr_i[1] = 7'(c + 1);
         @(negedge clk_i);
         check("fair_gnt", 32'(gnt_o), (c % 2 != 0) ? 0 : (((c / 2) % 2 == 0) ? 32'h1 : 32'h2));
      end
      step(); req_i = '0;
      @(negedge clk_i);

      // Stall: converter not ready for three cycles.
      step(); req_i = 2'b01; stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         check("stall_gnt", 32'(gnt_o), 0);
         check("stall_en", 32'(conv_en_o), 0);
         if (c < 2) step();
      end
      step(); stall = 1'b0;
      @(negedge clk_i); check("stall_release_gnt", 32'(gnt_o), 32'h1);
      step(); req_i = '0;
      @(negedge clk_i);

      // Read timeout: converter never returns data.
      step(); req_i = 2'b01; we_i = '0; addr_i[0] = 7'h33; no_valid = 1'b1;
      @(negedge clk_i); check("tmo_gnt", 32'(gnt_o), 32'h1);
      step(); req_i = '0;
      for (int c = 1; c < TMO; c++) begin
         @(negedge clk_i); check("tmo_wait_rsp", 32'(rsp_valid_o), 0);
         step();
      end
      @(negedge clk_i);
      check("tmo_rsp", 32'(rsp_valid_o), 32'h1);
      check("tmo_rsp_err", 32'(rsp_err_o), 1);
      check("tmo_rdata", rdata_o, 0);
      step(); no_valid = 1'b0;
      @(negedge clk_i); check("tmo_err_sticky", 32'(err_o), 1);
      step(); req_i = 2'b10; we_i = 2'b10; addr_i[1] = 7'h40; wdata_i[1] = 32'h1234_5678;
      @(negedge clk_i);
      step(); req_i = '0; we_i = '0;
      @(negedge clk_i);
      step();
      @(negedge clk_i); check("err_after_good", 32'(err_o), 1);

      // Reset while a write is in WR_WAIT.
      step(); req_i = 2'b10; we_i = 2'b10; addr_i[1] = 7'h41; wdata_i[1] = 32'hDEAD_BEEF;
      @(negedge clk_i); check("rstwr_gnt", 32'(gnt_o), 32'h2);
      step(); rst_ni = 1'b0; req_i = '0; we_i = '0;
      @(negedge clk_i); check("rstwr_no_rsp", 32'(rsp_valid_o), 0);
      step(); rst_ni = 1'b1; req_i = 2'b11;
      @(negedge clk_i); check("rstwr_first_gnt", 32'(gnt_o), 32'h1);
      step(); req_i = '0;
      @(negedge clk_i);

      // Randomized traffic; requesters hold each request until granted.
      g = '0;
      for (int c = 0; c < 800; c++) begin
         step();
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_i[i] && g[i]) req_i[i] = 1'b0;
            else if (!req_i[i] && $urandom_range(0, 2) == 0) begin
               req_i[i]   = 1'b1;
               we_i[i]    = 1'($urandom_range(0, 1));
               addr_i[i]  = 7'($urandom_range(0, 7));
               wdata_i[i] = $urandom;
            end
         end
         stall    = ($urandom_range(0, 7) == 0);
         no_valid = ($urandom_range(0, 15) == 0);
         @(negedge clk_i);
         g = gnt_o;
      end
      step(); req_i = '0; stall = 1'b0; no_valid = 1'b0;
      repeat (8) @(negedge clk_i);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
